// File: rtl/data_mem_pipe_if.sv
// Request/response bus of the pipelined data memory.
// The master issues loads/stores; the slave (the memory) answers with
// one in-order response per accepted request.
interface data_mem_pipe_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        fault_sticky;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_sticky
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_sticky
   );
endinterface

// File: rtl/data_mem_pipe.sv
// Big-endian, byte-addressable single-port data RAM with byte/half/word
// access, load extension, alignment/range faults, a READ_LAT-deep response
// pipeline and a one-word-per-cycle memory clear after reset.
// Storage is a word array; byte lane 0 (lowest address) lives in [31:24].
module data_mem_pipe #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic           clk,
   input  logic           reset,
   data_mem_pipe_if.slave bus
);
   localparam int unsigned NWORDS = DEPTH_BYTES / 4;
   localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NWORDS - 1);

   typedef enum logic {S_CLEAR, S_RUN} state_e;

   state_e            state_q, state_d;
   logic [WIDX_W-1:0] clr_idx_q, clr_idx_d;
   logic              clr_we;
   logic              ready;

   logic [31:0]       mem_q [0:NWORDS-1];

   logic              accept;
   logic              fault;
   logic [2:0]        nbytes;
   logic [32:0]       end_addr;
   logic [1:0]        lane;
   logic [WIDX_W-1:0] widx;
   logic [31:0]       rd_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       ld_data;
   logic [31:0]       wr_word;
   logic [3:0]        be;
   logic              st_we;

   logic [READ_LAT:1] vld_pipe_q;
   logic [READ_LAT:1] flt_pipe_q;
   logic [31:0]       rdata_pipe_q [1:READ_LAT];
   logic              sticky_q;

   // State and clear-index registers; reset restarts the clear from word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Clear walker: one zero word per cycle, then hand the port to requests.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we    = 1'b0;
      ready     = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we = !reset;
            if (clr_idx_q == LAST_IDX) state_d = S_RUN;
            else                       clr_idx_d = clr_idx_q + WIDX_W'(1);
         end
         S_RUN: ready = !reset;
         default: state_d = S_CLEAR;
      endcase
   end

   assign accept = bus.req_valid && ready;
   assign lane   = bus.req_addr[1:0];
   assign widx   = bus.req_addr[WIDX_W+1:2];
   assign rd_word = mem_q[widx];

   // Fault check in priority order; the end address is formed in 33 bits
   // so a request near 0xFFFFFFFF cannot wrap back into range.
   always_comb begin
      case (bus.req_size)
         2'b01:   nbytes = 3'd2;
         2'b10:   nbytes = 3'd4;
         default: nbytes = 3'd1;
      endcase
      end_addr = {1'b0, bus.req_addr} + 33'(nbytes);
      fault    = 1'b0;
      if (bus.req_size == 2'b11)
         fault = 1'b1;
      else if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
         fault = 1'b1;
      else if (end_addr > 33'(DEPTH_BYTES))
         fault = 1'b1;
   end

   // Load path: pick the addressed byte/half and extend it.
   always_comb begin
      case (lane)
         2'd0:    byte_sel = rd_word[31:24];
         2'd1:    byte_sel = rd_word[23:16];
         2'd2:    byte_sel = rd_word[15:8];
         default: byte_sel = rd_word[7:0];
      endcase
      half_sel = lane[1] ? rd_word[15:0] : rd_word[31:16];
      case (bus.req_size)
         2'b00:   ld_data = {(bus.req_unsigned ? 24'h0 : {24{byte_sel[7]}}), byte_sel};
         2'b01:   ld_data = {(bus.req_unsigned ? 16'h0 : {16{half_sel[15]}}), half_sel};
         2'b10:   ld_data = rd_word;
         default: ld_data = '0;
      endcase
   end

   // Store path: replicate right-justified data across lanes, enable only
   // the addressed bytes (be[3] is the lowest-address byte).
   always_comb begin
      wr_word = bus.req_wdata;
      be      = 4'b0000;
      case (bus.req_size)
         2'b00: begin
            wr_word = {4{bus.req_wdata[7:0]}};
            be      = 4'b1000 >> lane;
         end
         2'b01: begin
            wr_word = {2{bus.req_wdata[15:0]}};
            be      = lane[1] ? 4'b0011 : 4'b1100;
         end
         2'b10: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign st_we = accept && bus.req_write && !fault;

   // Array write: the clear owns the port in CLEAR, good stores in RUN.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_idx_q] <= '0;
      end else if (st_we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[widx][8*b +: 8] <= wr_word[8*b +: 8];
      end
   end

   // Response pipeline; data and fault are zeroed unless a real response rides in the slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q <= '0;
         flt_pipe_q <= '0;
         for (int i = 1; i <= READ_LAT; i++) rdata_pipe_q[i] <= '0;
      end else begin
         vld_pipe_q[1]   <= accept;
         flt_pipe_q[1]   <= accept && fault;
         rdata_pipe_q[1] <= (accept && !bus.req_write && !fault) ? ld_data : '0;
         for (int i = 2; i <= READ_LAT; i++) begin
            vld_pipe_q[i]   <= vld_pipe_q[i-1];
            flt_pipe_q[i]   <= flt_pipe_q[i-1];
            rdata_pipe_q[i] <= rdata_pipe_q[i-1];
         end
      end
   end

   // Sticky fault flag, set by any faulting response and held until reset.
   always_ff @(posedge clk) begin
      if (reset)                                               sticky_q <= 1'b0;
      else if (vld_pipe_q[READ_LAT] && flt_pipe_q[READ_LAT])   sticky_q <= 1'b1;
   end

   assign bus.req_ready    = ready;
   assign bus.rsp_valid    = vld_pipe_q[READ_LAT];
   assign bus.rsp_fault    = flt_pipe_q[READ_LAT];
   assign bus.rsp_rdata    = rdata_pipe_q[READ_LAT];
   assign bus.fault_sticky = sticky_q;
endmodule
